irq_controller: RTL

- Priority interrupt controller directly upstream of the multi-cycle MIPS core.
- Collects NUM_IRQ device request lines and one NMI source, latches and masks them, and drives the core's interrupt_r and NON_maskable_interrupt inputs.
- Consumes the core's INA acknowledge and an end-of-interrupt strobe.
- Presents the serviced source number as a vector the handler reads.

---
 rtl/irq_controller_pkg.sv | 14 +
 rtl/irq_controller_if.sv | 32 +++
 rtl/irq_controller_prio_enc.sv | 24 ++
 rtl/irq_controller.sv | 108 ++++++++++
 4 files changed

// File: rtl/irq_controller_pkg.sv
// Shared definitions for the priority interrupt controller: FSM encoding and
// default sizing constants.
package irq_controller_pkg;

    localparam int DEF_NUM_IRQ = 8;
    localparam int DEF_VEC_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_controller_if.sv
// Signal bundle between the interrupt controller, its device sources and the
// core. The controller uses the master view; sources and core use the slave view.
interface irq_controller_if #(
    parameter int NUM_IRQ = 8,
    parameter int VEC_W   = 3
);
    logic [NUM_IRQ-1:0] irq_src;
    logic               nmi_src;
    logic               cpu_busy;
    logic               ina;
    logic               eoi;
    logic               mask_we;
    logic [NUM_IRQ-1:0] mask_wdata;
    logic               interrupt_r;
    logic               NON_maskable_interrupt;
    logic [VEC_W-1:0]   irq_vector;
    logic               in_service;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] mask;

    modport master (
        input  irq_src, nmi_src, cpu_busy, ina, eoi, mask_we, mask_wdata,
        output interrupt_r, NON_maskable_interrupt, irq_vector, in_service,
               pending, mask
    );

    modport slave (
        output irq_src, nmi_src, cpu_busy, ina, eoi, mask_we, mask_wdata,
        input  interrupt_r, NON_maskable_interrupt, irq_vector, in_service,
               pending, mask
    );
endinterface

// File: rtl/irq_controller_prio_enc.sv
// Find-first-set over the unmasked pending bits; index 0 has the highest priority.
module irq_prio_enc #(
    parameter int NUM_IRQ = 8,
    parameter int VEC_W   = 3
) (
    input  logic [NUM_IRQ-1:0] i_req,
    output logic               o_valid,
    output logic [VEC_W-1:0]   o_idx
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        // Scan downward so the lowest set index is the last one written.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_valid = 1'b1;
                o_idx   = VEC_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Priority interrupt controller feeding the multi-cycle MIPS core: edge-latched
// maskable sources with a REQ/SERVICE handshake, plus an independent NMI path.
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int                 NUM_IRQ    = DEF_NUM_IRQ,
    parameter int                 VEC_W      = DEF_VEC_W,
    parameter logic [NUM_IRQ-1:0] MASK_RESET = '0
) (
    input  logic        clock,
    input  logic        reset_n,
    irq_controller_if.master bus
);

    irq_state_t         r_state;
    irq_state_t         w_state_nxt;
    logic [NUM_IRQ-1:0] r_irq_d;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_mask;
    logic [VEC_W-1:0]   r_vec;
    logic               r_nmi_d;
    logic               r_nmi_pending;

    logic [NUM_IRQ-1:0] w_irq_edge;
    logic [NUM_IRQ-1:0] w_clr;
    logic [NUM_IRQ-1:0] w_cand_req;
    logic [VEC_W-1:0]   w_cand_idx;
    logic [VEC_W-1:0]   w_vec_nxt;
    logic               w_cand_valid;
    logic               w_nmi_edge;
    logic               w_irq_ack;

    assign w_irq_edge = bus.irq_src & ~r_irq_d;
    assign w_nmi_edge = bus.nmi_src & ~r_nmi_d;
    assign w_cand_req = r_pending & ~r_mask;

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .VEC_W   (VEC_W)
    ) u_prio_enc (
        .i_req   (w_cand_req),
        .o_valid (w_cand_valid),
        .o_idx   (w_cand_idx)
    );

    // While the NMI is raised it owns every ina, so the maskable FSM never sees it.
    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        w_irq_ack   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cand_valid && !bus.cpu_busy && !r_nmi_pending) begin
                    w_state_nxt = ST_REQ;
                    w_vec_nxt   = w_cand_idx;
                end
            end
            ST_REQ: begin
                if (bus.ina && !r_nmi_pending) begin
                    w_irq_ack   = 1'b1;
                    w_state_nxt = ST_SERVICE;
                end else if (r_mask[r_vec]) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (bus.eoi) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_clr = w_irq_ack ? (NUM_IRQ'(1) << r_vec) : '0;

    // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_irq_d       <= '0;
            r_pending     <= '0;
            r_mask        <= MASK_RESET;
            r_vec         <= '0;
            r_nmi_d       <= 1'b0;
            r_nmi_pending <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_vec         <= w_vec_nxt;
            r_irq_d       <= bus.irq_src;
            r_nmi_d       <= bus.nmi_src;
            // A fresh edge on the bit being acknowledged survives the clear.
            r_pending     <= (r_pending & ~w_clr) | w_irq_edge;
            r_nmi_pending <= w_nmi_edge | (r_nmi_pending & ~bus.ina);
            if (bus.mask_we) begin
                r_mask <= bus.mask_wdata;
            end
        end
    end

    assign bus.interrupt_r            = (r_state == ST_REQ);
    assign bus.in_service             = (r_state == ST_SERVICE);
    assign bus.NON_maskable_interrupt = r_nmi_pending;
    assign bus.irq_vector             = r_vec;
    assign bus.pending                = r_pending;
    assign bus.mask                   = r_mask;

endmodule
